skid_stage: RTL and testbench
=============================

Name: skid_stage

Overview:
- Two-entry ready/valid pipeline register (skid buffer) that moves a W-bit word from a producer to a consumer.
- `dffe` is the plain capture-on-enable write side. This block is the matching drain side with backpressure.
- Registers the downstream `out_ready` path so long combinational ready chains are broken between queue pipeline stages.
- Sustains one word per cycle when the consumer never stalls.

Parameters:
W, 32, data word width in bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer presents in_data
in_ready  output  1  stage can accept a word this cycle
in_data  input  W  producer word
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  W  word presented to consumer
occ  output  2  number of words held (0..2)

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low. All state changes on the rising edge of `clk`; `rst_n` low clears state immediately, independent of `clk`.
- Reset values: state EMPTY; `out_valid`=0; `in_ready`=1; `occ`=0; `out_data`=0; skid register=0.
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A word transfers only on a fire.
- Producer rules: a producer holding `in_valid` high keeps `in_data` stable until in_fire. The stage never drops or duplicates a word.
- Output registering:
  - `in_ready`, `out_valid` and `occ` are decoded from state registers only. None is combinationally dependent on `out_ready` or `in_valid`.
  - `out_data` comes straight from the main register.
- Storage: main register (drives `out_data`) and skid register.
- States and transitions:
  - EMPTY (occ=0, in_ready=1, out_valid=0):
    - in_fire: main<=in_data, go to ONE.
    - Otherwise stay.
  - ONE (occ=1, in_ready=1, out_valid=1):
    - in_fire & out_fire: main<=in_data, stay ONE.
    - in_fire only: skid<=in_data, go to FULL.
    - out_fire only: go to EMPTY.
    - Neither: hold.
  - FULL (occ=2, in_ready=0, out_valid=1):
    - out_fire: main<=skid, go to ONE.
    - Otherwise hold. in_valid is ignored because in_ready=0.
- Latency and throughput:
  - One cycle from in_fire to out_valid when starting from EMPTY.
  - Back-to-back throughput is 1 word/cycle with out_ready held high.
- Ordering: strict FIFO. The skid word is always older than any word accepted afterwards.
- Main register holds its value while out_valid & !out_ready. `out_data` must not change while stalled.
- The content of main in EMPTY is don't-care. No clearing on drain is required.
- Reset mid-transfer: all held words are discarded. The first cycle after rst_n rises behaves as EMPTY.
- A word presented during reset is not accepted.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle with occ=2 -> immediately occ=0, out_valid=0, in_ready=1, out_data=0 without a clock edge.
- Streaming, W=32: out_ready=1, send 0x11,0x22,0x33,0x44 on consecutive cycles -> each appears on out_data exactly one cycle after acceptance; occ stays 1 during streaming; no bubbles.
- Stall fill: out_ready=0, in_valid=1 with 0xA5, then 0x5A -> both accepted; occ=2, in_ready=0; third word 0xFF is held off and not accepted; out_data stays 0xA5 for the full stall.
- Drain after stall: from FULL {0xA5,0x5A}, pulse out_ready 1 cycle -> out_data=0x5A, occ=1, in_ready=1; 0xFF is accepted the same cycle in_ready is seen high, and the drain order is 0xA5, 0x5A, 0xFF.
- Simultaneous events: in ONE with main=0x01, in_fire and out_fire together with in_data=0x02 -> next cycle out_data=0x02, occ=1.
- Random soak: random in_valid/out_ready for 10k cycles against a scoreboard queue -> output sequence equals input sequence, occ never exceeds 2, and in_ready/out_valid never change in the same cycle as a changing out_ready input.

Source files
------------

// File: rtl/skid_stage.sv
// Two-entry ready/valid skid buffer.
// Handshake outputs decode from state only, breaking the out_ready path.
module skid_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   main_q;
  logic [W-1:0]   main_nxt;
  logic [W-1:0]   skid_q;
  logic [W-1:0]   skid_nxt;
  logic           in_fire;
  logic           out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  // Handshake flags and occupancy come from state alone
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occ       = 2'd0;
    unique case (state)
      EMPTY: begin
        in_ready  = 1'b1;
      end
      ONE: begin
        out_valid = 1'b1;
        occ       = 2'd1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occ       = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
      end
    endcase
  end

  // Next state and storage updates; skid word always drains before newer ones
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          main_nxt  = in_data;
          state_nxt = ONE;
        end
      end
      ONE: begin
        case ({in_fire, out_fire})
          2'b11: main_nxt = in_data;
          2'b10: begin
            skid_nxt  = in_data;
            state_nxt = FULL;
          end
          2'b01: state_nxt = EMPTY;
          default: state_nxt = ONE;
        endcase
      end
      FULL: begin
        if (out_fire) begin
          main_nxt  = skid_q;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State and data registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_skid_stage.sv
// Scoreboard bench for skid_stage.
// Words queue on acceptance and are checked against out_data in order.
module tb_skid_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occ;

  int compared;
  int mismatched;
  logic [31:0] q[$];

  skid_stage #(.W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle from a negedge, update the model at the posedge
  task automatic advance(input logic v, input logic [31:0] d,
                         input logic r);
    bit ifire;
    bit ofire;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    ifire = v && (q.size() < 2);
    ofire = r && (q.size() > 0);
    if (ofire) void'(q.pop_front());
    if (ifire) q.push_back(d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    q.delete();
    @(negedge clk);
    compared++;
    if (occ !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_data !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_state: got occ=%0d ir=%b ov=%b d=%h want 0 1 0 0",
               occ, in_ready, out_valid, out_data);
    end
    rst_n = 1'b1;
    advance(1'b1, 32'hC1, 1'b0);
    advance(1'b1, 32'hC2, 1'b0);
    compared++;
    if (occ !== 2'd2) begin
      mismatched++;
      $display("FAIL reset_fill: got occ=%0d want 2", occ);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    compared++;
    if (occ !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_data !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_async: got occ=%0d ir=%b ov=%b d=%h want 0 1 0 0",
               occ, in_ready, out_valid, out_data);
    end
    in_valid = 1'b1;
    in_data  = 32'h77;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (occ !== 2'd0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_no_accept: got occ=%0d ov=%b want 0 0",
               occ, out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] w [4];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      advance(1'b1, w[i], 1'b1);
      compared++;
      if (occ !== 2'd1 || out_valid !== 1'b1 || out_data !== w[i]) begin
        mismatched++;
        $display("FAIL stream_%0d: got occ=%0d ov=%b d=%h want 1 1 %h",
                 i, occ, out_valid, out_data, w[i]);
      end
    end
    advance(1'b0, 32'h0, 1'b1);
    compared++;
    if (occ !== 2'd0 || q.size() != 0) begin
      mismatched++;
      $display("FAIL stream_drain: got occ=%0d want 0", occ);
    end
  endtask

  task automatic test_stall_fill();
    advance(1'b1, 32'hA5, 1'b0);
    compared++;
    if (occ !== 2'd1 || out_data !== 32'hA5) begin
      mismatched++;
      $display("FAIL stall_first: got occ=%0d d=%h want 1 a5", occ, out_data);
    end
    advance(1'b1, 32'h5A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (occ !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA5 ||
          q.size() != 2) begin
        mismatched++;
        $display("FAIL stall_full_%0d: got occ=%0d ir=%b d=%h want 2 0 a5",
                 i, occ, in_ready, out_data);
      end
      advance(1'b1, 32'hFF, 1'b0);
    end
  endtask

  task automatic test_drain();
    logic [31:0] order [3];
    logic [31:0] seen [$];
    order[0] = 32'hA5; order[1] = 32'h5A; order[2] = 32'hFF;
    seen.push_back(out_data);
    advance(1'b1, 32'hFF, 1'b1);
    compared++;
    if (out_data !== 32'h5A || occ !== 2'd1 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL drain_pulse: got d=%h occ=%0d ir=%b want 5a 1 1",
               out_data, occ, in_ready);
    end
    advance(1'b1, 32'hFF, 1'b0);
    compared++;
    if (occ !== 2'd2 || out_data !== 32'h5A) begin
      mismatched++;
      $display("FAIL drain_accept: got occ=%0d d=%h want 2 5a", occ, out_data);
    end
    while (q.size() > 0 && seen.size() < 4) begin
      compared++;
      if (out_data !== q[0]) begin
        mismatched++;
        $display("FAIL drain_front: got %h want %h", out_data, q[0]);
      end
      if (seen[seen.size()-1] !== out_data) seen.push_back(out_data);
      advance(1'b0, 32'h0, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (i >= seen.size() || seen[i] !== order[i]) begin
        mismatched++;
        $display("FAIL drain_order_%0d: got %h want %h", i,
                 (i < seen.size()) ? seen[i] : 32'hx, order[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    advance(1'b1, 32'h01, 1'b0);
    compared++;
    if (occ !== 2'd1 || out_data !== 32'h01) begin
      mismatched++;
      $display("FAIL simul_setup: got occ=%0d d=%h want 1 01", occ, out_data);
    end
    advance(1'b1, 32'h02, 1'b1);
    compared++;
    if (occ !== 2'd1 || out_data !== 32'h02) begin
      mismatched++;
      $display("FAIL simul_both: got occ=%0d d=%h want 1 02", occ, out_data);
    end
    advance(1'b0, 32'h0, 1'b1);
    compared++;
    if (occ !== 2'd0) begin
      mismatched++;
      $display("FAIL simul_drain: got occ=%0d want 0", occ);
    end
  endtask

  task automatic test_soak();
    logic v;
    logic r;
    logic [31:0] d;
    logic ir0;
    logic ov0;
    bit ifire;
    bit ofire;
    r = out_ready;
    for (int c = 0; c < 10000; c++) begin
      compared++;
      if (occ !== 2'(q.size()) || occ > 2'd2) begin
        mismatched++;
        $display("FAIL soak_occ c=%0d: got %0d want %0d", c, occ, q.size());
      end
      compared++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
        mismatched++;
        $display("FAIL soak_flags c=%0d: got ir=%b ov=%b want %b %b", c,
                 in_ready, out_valid, q.size() < 2, q.size() > 0);
      end
      if (q.size() > 0) begin
        compared++;
        if (out_data !== q[0]) begin
          mismatched++;
          $display("FAIL soak_data c=%0d: got %h want %h", c, out_data, q[0]);
        end
      end
      ir0 = in_ready;
      ov0 = out_valid;
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = $urandom;
      if (!(in_valid && (q.size() == 2)) || !v) in_data = d;
      in_valid  = v;
      out_ready = r;
      #1;
      compared++;
      if (in_ready !== ir0 || out_valid !== ov0) begin
        mismatched++;
        $display("FAIL soak_comb c=%0d: got ir=%b ov=%b want %b %b", c,
                 in_ready, out_valid, ir0, ov0);
      end
      @(posedge clk);
      ifire = v && (q.size() < 2);
      ofire = r && (q.size() > 0);
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(in_data);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) advance(1'b0, 32'h0, 1'b1);
    compared++;
    if (occ !== 2'd0 || q.size() != 0) begin
      mismatched++;
      $display("FAIL soak_final: got occ=%0d want 0", occ);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_streaming();
    test_stall_fill();
    test_drain();
    test_simultaneous();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
